ccip_txn_monitor: RTL and testbench
===================================

// Module: ccip_txn_monitor
// PURPOSE
//  Synthesizable, multi-channel CCI-P transaction monitor. Sits beside the AFU on CCI-P request/response channels.
//  Tracks outstanding requests per channel by mdata tag, counts requests and response beats.
//  Flags duplicate-tag issues, orphan responses and hung channels; sizes and counts are run-time observable.
// PARAMETERS
//  NUM_CH       2     number of monitored request/response channel pairs (ch0 = C0 read, ch1 = C1 write)
//  TAG_W        5     low mdata bits used as tracking tag; 2**TAG_W tracker entries per channel
//  CNT_W        32    width of every statistics counter; all counters saturate at all-ones
//  TIMEOUT_CYC  4096  response-silence cycles before hang is flagged; 0 disables hang detection
// PORTS
//  clk               in   1               CCI-P clock
//  SoftReset_n       in   1               synchronous active-low reset
//  req_valid         in   NUM_CH          request issued on channel c this cycle
//  req_tag           in   NUM_CH*TAG_W    request tag, slice c
//  req_len           in   NUM_CH*2        cache lines minus one (ccip_len_t encoding), slice c
//  rsp_valid         in   NUM_CH          response beat on channel c this cycle
//  rsp_tag           in   NUM_CH*TAG_W    response tag, slice c
//  rsp_pack          in   NUM_CH          packed response: completes entry regardless of beats left
//  stat_clear        in   1               pulse: clear counters and sticky flags; tracker state kept
//  req_cnt           out  NUM_CH*CNT_W    requests accepted
//  rsp_cnt           out  NUM_CH*CNT_W    response beats seen, including orphans
//  outstanding       out  NUM_CH*(TAG_W+1) live entries
//  peak_outstanding  out  NUM_CH*(TAG_W+1) high-water mark of outstanding
//  err_dup           out  NUM_CH          sticky: request on an already-live tag
//  err_orphan        out  NUM_CH          sticky: response on a free tag
//  hang              out  NUM_CH          sticky: TIMEOUT_CYC silent cycles with outstanding>0
//  err_pulse         out  1               one-cycle pulse, registered, on any new dup/orphan/hang event
//  lat_sum           out  NUM_CH*CNT_W    summed completion latency (feature macro)
//  lat_max           out  NUM_CH*16       max completion latency (feature macro)
// BEHAVIOUR
//  - Reset: SoftReset_n low at a clk edge zeroes all entries, counters, flags and outputs.
//    Inputs are ignored while SoftReset_n is low. Reset mid-flight discards live entries silently.
//  - Tracker entry = {valid, beats_left[1:0]}. Request sets valid and beats_left=len.
//  - Response on a valid entry: rsp_pack or beats_left==0 frees the entry; otherwise beats_left decrements.
//  - Response on an invalid entry: err_orphan set; tracker unchanged; rsp_cnt still increments.
//  - Request on a valid entry (after this cycle's response): err_dup set; entry overwritten with the new len/timestamp.
//    outstanding is unchanged and req_cnt increments.
//  - Same cycle, same channel: response evaluated against pre-cycle state, then request.
//    A response freeing tag T and a request on T in the same cycle is legal: no error, outstanding net 0.
//    A response on free T plus a request on T is an orphan; the request allocates normally.
//  - Tags of different channels are independent.
//  - outstanding(n+1) = outstanding(n) + alloc - free. peak_outstanding updates in the same cycle.
//  - All outputs are registered: 1-cycle latency from an input edge to its counter/flag. err_pulse is asserted in that same cycle.
//  - Hang: per-channel silence counter resets on any rsp_valid or when outstanding==0; otherwise increments.
//    hang sets when the counter reaches TIMEOUT_CYC. The counter holds until a response or clear.
//  - stat_clear: zeroes req_cnt, rsp_cnt, peak_outstanding (to the current outstanding), sticky flags, lat_*.
//    Events in the clear cycle are lost. Tracker entries and outstanding are untouched.
// CONFIGURATION
//  CCIP_TXN_MON_LATENCY_EN defined:
//  - Free-running 16-bit cycle stamp; each entry also stores the issue stamp.
//  - On entry free, latency = (now - issue) mod 2**16 is added (saturating) to lat_sum; lat_max holds the max.
//  - Latency measured on the freeing response only; dup overwrite restarts the stamp.
//  Undefined: no stamp storage; lat_sum and lat_max tied to 0; ports remain present.
// STRUCTURE
//  - ase_pkg gains mon_entry_t {logic valid; logic [1:0] beats_left;} and the MON_TS_W=16 constant.
//  - Sub-module ccip_txn_mon_chan: one channel's tracker array, counters and hang timer.
//    Instantiated NUM_CH times by generate. The top level holds the stamp counter, err_pulse OR-reduce and slicing.
// TESTING
//  1. ch0 req tag3 len0 @t, rsp tag3 @t+10 -> req_cnt0=1, rsp_cnt0=1, outstanding0 1 then 0, peak=1, lat_max0=10 (EN).
//  2. ch1 req tag5 len3, 3 unpacked rsps -> outstanding1 stays 1; 4th rsp -> 0; rsp_cnt1=4. Repeat with one rsp_pack=1 -> freed at once.
//  3. ch0 rsp tag7 with nothing live -> err_orphan0=1, err_pulse for 1 cycle, outstanding0=0, rsp_cnt0=1.
//  4. ch0 req tag2 twice -> err_dup0=1, outstanding0=1, req_cnt0=2. Same cycle: rsp freeing tag2 + req tag2 -> no error, outstanding0=1.
//  5. TIMEOUT_CYC=16, ch0 req tag1 with no rsp -> hang0 rises 16 cycles after outstanding0 becomes 1. stat_clear -> hang0=0, outstanding0=1.
//  6. 8 live tags then SoftReset_n low 1 cycle -> all outputs 0; following rsp tag0 -> err_orphan0=1.

Source files
------------

// File: rtl/ase_pkg.sv
// Shared CCI-P monitor types: tracker entry layout and cycle-stamp width.
package ase_pkg;

  localparam int MON_TS_W = 16;

  typedef struct packed {
    logic       valid;
    logic [1:0] beats_left;
  } mon_entry_t;

endpackage

// File: rtl/ccip_txn_mon_chan.sv
// One monitored CCI-P channel: tag tracker, stats counters, hang timer.
// Latency stamping is built only with CCIP_TXN_MON_LATENCY_EN.
module ccip_txn_mon_chan
  import ase_pkg::*;
#(
  parameter int TAG_W       = 5,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               SoftReset_n,
  input  logic               reqValid,
  input  logic [TAG_W-1:0]   reqTag,
  input  logic [1:0]         reqLen,
  input  logic               rspValid,
  input  logic [TAG_W-1:0]   rspTag,
  input  logic               rspPack,
  input  logic               statClear,
`ifdef CCIP_TXN_MON_LATENCY_EN
  input  logic [MON_TS_W-1:0] now,
  output logic [CNT_W-1:0]   latSum,
  output logic [15:0]        latMax,
`endif
  output logic [CNT_W-1:0]   reqCnt,
  output logic [CNT_W-1:0]   rspCnt,
  output logic [TAG_W:0]     outstanding,
  output logic [TAG_W:0]     peakOutstanding,
  output logic               errDup,
  output logic               errOrphan,
  output logic               hang,
  output logic               errEvt
);

  localparam int DEPTH = 1 << TAG_W;
  localparam int OW    = TAG_W + 1;
  localparam int HW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [HW-1:0] TO = HW'(TIMEOUT_CYC);

  mon_entry_t        ent [DEPTH];
  mon_entry_t        rspEnt;
  logic              rspHit;
  logic              orphan;
  logic              freeE;
  logic              reqLive;
  logic              dup;
  logic              alloc;
  logic [OW-1:0]     outNext;
  logic [HW-1:0]     silCnt;
  logic [HW-1:0]     silNext;
  logic              hangHit;

  always_comb begin
    rspEnt  = ent[rspTag];
    rspHit  = rspValid && rspEnt.valid;
    orphan  = rspValid && !rspEnt.valid;
    freeE   = rspHit && (rspPack || rspEnt.beats_left == 2'd0);
    // a tag freed this cycle may be reissued without a dup
    reqLive = ent[reqTag].valid && !(freeE && rspTag == reqTag);
    dup     = reqValid && reqLive;
    alloc   = reqValid && !reqLive;
    outNext = outstanding + OW'(alloc) - OW'(freeE);
    silNext = '0;
    if (rspValid || outstanding == '0)
      silNext = '0;
    else if (silCnt == TO)
      silNext = silCnt;
    else
      silNext = silCnt + HW'(1);
    hangHit = (TIMEOUT_CYC != 0) && (silNext == TO);
    errEvt  = !statClear && (dup || orphan || (hangHit && !hang));
  end

  always_ff @(posedge clk) begin
    if (!SoftReset_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      reqCnt          <= '0;
      rspCnt          <= '0;
      outstanding     <= '0;
      peakOutstanding <= '0;
      errDup          <= 1'b0;
      errOrphan       <= 1'b0;
      hang            <= 1'b0;
      silCnt          <= '0;
    end else begin
      if (rspHit) begin
        if (freeE)
          ent[rspTag] <= '0;
        else
          ent[rspTag] <= {1'b1, rspEnt.beats_left - 2'd1};
      end
      if (reqValid)
        ent[reqTag] <= {1'b1, reqLen};
      outstanding <= outNext;
      silCnt      <= statClear ? '0 : silNext;
      if (statClear) begin
        reqCnt          <= '0;
        rspCnt          <= '0;
        peakOutstanding <= outNext;
        errDup          <= 1'b0;
        errOrphan       <= 1'b0;
        hang            <= 1'b0;
      end else begin
        if (reqValid && !(&reqCnt)) reqCnt <= reqCnt + CNT_W'(1);
        if (rspValid && !(&rspCnt)) rspCnt <= rspCnt + CNT_W'(1);
        if (outNext > peakOutstanding) peakOutstanding <= outNext;
        errDup    <= errDup | dup;
        errOrphan <= errOrphan | orphan;
        hang      <= hang | hangHit;
      end
    end
  end

`ifdef CCIP_TXN_MON_LATENCY_EN
  logic [MON_TS_W-1:0] stamp [DEPTH];
  logic [MON_TS_W-1:0] lat;
  logic [CNT_W:0]      latAdd;

  always_comb begin
    lat    = now - stamp[rspTag];
    latAdd = {1'b0, latSum} + (CNT_W + 1)'(lat);
  end

  always_ff @(posedge clk) begin
    if (SoftReset_n && reqValid)
      stamp[reqTag] <= now;
  end

  always_ff @(posedge clk) begin
    if (!SoftReset_n) begin
      latSum <= '0;
      latMax <= '0;
    end else if (statClear) begin
      latSum <= '0;
      latMax <= '0;
    end else if (freeE) begin
      latSum <= latAdd[CNT_W] ? '1 : latAdd[CNT_W-1:0];
      if (lat > latMax) latMax <= lat;
    end
  end
`endif

endmodule

// File: rtl/ccip_txn_monitor.sv
// Multi-channel CCI-P transaction monitor (ch0 = C0 read, ch1 = C1 write).
// Define CCIP_TXN_MON_LATENCY_EN to build completion-latency statistics.
module ccip_txn_monitor
  import ase_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int TAG_W       = 5,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      SoftReset_n,
  input  logic [NUM_CH-1:0]         req_valid,
  input  logic [NUM_CH*TAG_W-1:0]   req_tag,
  input  logic [NUM_CH*2-1:0]       req_len,
  input  logic [NUM_CH-1:0]         rsp_valid,
  input  logic [NUM_CH*TAG_W-1:0]   rsp_tag,
  input  logic [NUM_CH-1:0]         rsp_pack,
  input  logic                      stat_clear,
  output logic [NUM_CH*CNT_W-1:0]   req_cnt,
  output logic [NUM_CH*CNT_W-1:0]   rsp_cnt,
  output logic [NUM_CH*(TAG_W+1)-1:0] outstanding,
  output logic [NUM_CH*(TAG_W+1)-1:0] peak_outstanding,
  output logic [NUM_CH-1:0]         err_dup,
  output logic [NUM_CH-1:0]         err_orphan,
  output logic [NUM_CH-1:0]         hang,
  output logic                      err_pulse,
  output logic [NUM_CH*CNT_W-1:0]   lat_sum,
  output logic [NUM_CH*16-1:0]      lat_max
);

  localparam int OW = TAG_W + 1;

  logic [NUM_CH-1:0] chEvt;

`ifdef CCIP_TXN_MON_LATENCY_EN
  logic [MON_TS_W-1:0] now;

  always_ff @(posedge clk) begin
    if (!SoftReset_n) now <= '0;
    else              now <= now + MON_TS_W'(1);
  end
`else
  assign lat_sum = '0;
  assign lat_max = '0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ccip_txn_mon_chan #(
      .TAG_W       (TAG_W),
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_chan (
      .clk             (clk),
      .SoftReset_n     (SoftReset_n),
      .reqValid        (req_valid[c]),
      .reqTag          (req_tag[c*TAG_W +: TAG_W]),
      .reqLen          (req_len[c*2 +: 2]),
      .rspValid        (rsp_valid[c]),
      .rspTag          (rsp_tag[c*TAG_W +: TAG_W]),
      .rspPack         (rsp_pack[c]),
      .statClear       (stat_clear),
`ifdef CCIP_TXN_MON_LATENCY_EN
      .now             (now),
      .latSum          (lat_sum[c*CNT_W +: CNT_W]),
      .latMax          (lat_max[c*16 +: 16]),
`endif
      .reqCnt          (req_cnt[c*CNT_W +: CNT_W]),
      .rspCnt          (rsp_cnt[c*CNT_W +: CNT_W]),
      .outstanding     (outstanding[c*OW +: OW]),
      .peakOutstanding (peak_outstanding[c*OW +: OW]),
      .errDup          (err_dup[c]),
      .errOrphan       (err_orphan[c]),
      .hang            (hang[c]),
      .errEvt          (chEvt[c])
    );
  end

  // registered so the pulse lines up with the flag it reports
  always_ff @(posedge clk) begin
    if (!SoftReset_n) err_pulse <= 1'b0;
    else              err_pulse <= |chEvt;
  end

endmodule

// File: tb/tb_ccip_txn_monitor.sv
// Directed bench for ccip_txn_monitor (NUM_CH=2, TAG_W=5, TIMEOUT_CYC=16).
module tb_ccip_txn_monitor;

  localparam int NCH = 2;
  localparam int TW  = 5;
  localparam int CW  = 32;

  logic              clk = 1'b0;
  logic              SoftReset_n;
  logic [NCH-1:0]    req_valid;
  logic [NCH*TW-1:0] req_tag;
  logic [NCH*2-1:0]  req_len;
  logic [NCH-1:0]    rsp_valid;
  logic [NCH*TW-1:0] rsp_tag;
  logic [NCH-1:0]    rsp_pack;
  logic              stat_clear;
  logic [NCH*CW-1:0] req_cnt;
  logic [NCH*CW-1:0] rsp_cnt;
  logic [NCH*(TW+1)-1:0] outstanding;
  logic [NCH*(TW+1)-1:0] peak_outstanding;
  logic [NCH-1:0]    err_dup;
  logic [NCH-1:0]    err_orphan;
  logic [NCH-1:0]    hang;
  logic              err_pulse;
  logic [NCH*CW-1:0] lat_sum;
  logic [NCH*16-1:0] lat_max;

  int passed = 0;
  int total  = 0;

  ccip_txn_monitor #(
    .NUM_CH(NCH), .TAG_W(TW), .CNT_W(CW), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .SoftReset_n(SoftReset_n),
    .req_valid(req_valid), .req_tag(req_tag), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_pack(rsp_pack),
    .stat_clear(stat_clear),
    .req_cnt(req_cnt), .rsp_cnt(rsp_cnt),
    .outstanding(outstanding), .peak_outstanding(peak_outstanding),
    .err_dup(err_dup), .err_orphan(err_orphan), .hang(hang),
    .err_pulse(err_pulse), .lat_sum(lat_sum), .lat_max(lat_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid  = '0;
    req_tag    = '0;
    req_len    = '0;
    rsp_valid  = '0;
    rsp_tag    = '0;
    rsp_pack   = '0;
    stat_clear = 1'b0;
  endtask

  task automatic req(input int ch, input int tag, input int len);
    req_valid[ch]       = 1'b1;
    req_tag[ch*TW +: TW] = TW'(tag);
    req_len[ch*2 +: 2]  = 2'(len);
  endtask

  task automatic rsp(input int ch, input int tag, input bit pack);
    rsp_valid[ch]        = 1'b1;
    rsp_tag[ch*TW +: TW] = TW'(tag);
    rsp_pack[ch]         = pack;
  endtask

  task automatic doReset();
    idle();
    SoftReset_n = 1'b0;
    tick();
    SoftReset_n = 1'b1;
  endtask

  initial begin
    idle();
    SoftReset_n = 1'b0;
    tick();
    tick();
    SoftReset_n = 1'b1;

    chk("rst_req_cnt", 64'(req_cnt), 64'd0);
    chk("rst_outst", 64'(outstanding), 64'd0);
    chk("rst_flags", 64'({err_dup, err_orphan, hang, err_pulse}), 64'd0);

    // 1: single-beat read, latency 10
    req(0, 3, 0);
    tick();
    idle();
    chk("t1_outst_1", 64'(outstanding[5:0]), 64'd1);
    chk("t1_req_cnt", 64'(req_cnt[31:0]), 64'd1);
    repeat (9) tick();
    rsp(0, 3, 1'b0);
    tick();
    idle();
    chk("t1_outst_0", 64'(outstanding[5:0]), 64'd0);
    chk("t1_rsp_cnt", 64'(rsp_cnt[31:0]), 64'd1);
    chk("t1_peak", 64'(peak_outstanding[5:0]), 64'd1);
`ifdef CCIP_TXN_MON_LATENCY_EN
    chk("t1_lat_max", 64'(lat_max[15:0]), 64'd10);
    chk("t1_lat_sum", 64'(lat_sum[31:0]), 64'd10);
`else
    chk("t1_lat_max", 64'(lat_max), 64'd0);
    chk("t1_lat_sum", 64'(lat_sum), 64'd0);
`endif

    // 2: four-beat write on ch1, then packed completion
    req(1, 5, 3);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      rsp(1, 5, 1'b0);
      tick();
      idle();
    end
    chk("t2_outst_live", 64'(outstanding[11:6]), 64'd1);
    rsp(1, 5, 1'b0);
    tick();
    idle();
    chk("t2_outst_done", 64'(outstanding[11:6]), 64'd0);
    chk("t2_rsp_cnt", 64'(rsp_cnt[63:32]), 64'd4);
    req(1, 5, 3);
    tick();
    rsp(1, 5, 1'b1);
    idle();
    rsp(1, 5, 1'b1);
    tick();
    idle();
    chk("t2_pack_outst", 64'(outstanding[11:6]), 64'd0);
    chk("t2_pack_rsp_cnt", 64'(rsp_cnt[63:32]), 64'd5);
    chk("t2_req_cnt", 64'(req_cnt[63:32]), 64'd2);
    chk("t2_no_orphan", 64'(err_orphan), 64'd0);

    // 3: orphan response
    doReset();
    rsp(0, 7, 1'b0);
    tick();
    idle();
    chk("t3_orphan", 64'(err_orphan[0]), 64'd1);
    chk("t3_pulse", 64'(err_pulse), 64'd1);
    chk("t3_outst", 64'(outstanding[5:0]), 64'd0);
    chk("t3_rsp_cnt", 64'(rsp_cnt[31:0]), 64'd1);
    tick();
    chk("t3_pulse_gone", 64'(err_pulse), 64'd0);
    chk("t3_sticky", 64'(err_orphan[0]), 64'd1);

    // 4: duplicate tag, then same-cycle free + reissue
    doReset();
    req(0, 2, 0);
    tick();
    tick();
    idle();
    chk("t4_dup", 64'(err_dup[0]), 64'd1);
    chk("t4_dup_pulse", 64'(err_pulse), 64'd1);
    chk("t4_outst", 64'(outstanding[5:0]), 64'd1);
    chk("t4_req_cnt", 64'(req_cnt[31:0]), 64'd2);
    stat_clear = 1'b1;
    tick();
    idle();
    chk("t4_clr_dup", 64'(err_dup[0]), 64'd0);
    chk("t4_clr_req_cnt", 64'(req_cnt[31:0]), 64'd0);
    chk("t4_clr_peak", 64'(peak_outstanding[5:0]), 64'd1);
    rsp(0, 2, 1'b0);
    req(0, 2, 0);
    tick();
    idle();
    chk("t4_swap_flags", 64'({err_dup, err_orphan, err_pulse}), 64'd0);
    chk("t4_swap_outst", 64'(outstanding[5:0]), 64'd1);
    chk("t4_swap_req", 64'(req_cnt[31:0]), 64'd1);
    req(1, 2, 0);
    tick();
    idle();
    chk("t4_ch1_indep", 64'(err_dup[1]), 64'd0);
    chk("t4_ch1_outst", 64'(outstanding[11:6]), 64'd1);

    // 5: hang after 16 silent cycles, cleared by stat_clear
    doReset();
    req(0, 1, 0);
    tick();
    idle();
    repeat (15) tick();
    chk("t5_no_hang_yet", 64'(hang[0]), 64'd0);
    tick();
    chk("t5_hang", 64'(hang[0]), 64'd1);
    chk("t5_hang_pulse", 64'(err_pulse), 64'd1);
    stat_clear = 1'b1;
    tick();
    idle();
    chk("t5_clr_hang", 64'(hang[0]), 64'd0);
    chk("t5_clr_outst", 64'(outstanding[5:0]), 64'd1);

    // 6: reset with eight live tags
    doReset();
    for (int t = 0; t < 8; t++) begin
      req(0, t, 1);
      tick();
    end
    idle();
    chk("t6_outst_8", 64'(outstanding[5:0]), 64'd8);
    chk("t6_peak_8", 64'(peak_outstanding[5:0]), 64'd8);
    SoftReset_n = 1'b0;
    tick();
    chk("t6_rst_outst", 64'(outstanding), 64'd0);
    chk("t6_rst_peak", 64'(peak_outstanding), 64'd0);
    chk("t6_rst_cnt", 64'(req_cnt), 64'd0);
    SoftReset_n = 1'b1;
    rsp(0, 0, 1'b0);
    tick();
    idle();
    chk("t6_orphan", 64'(err_orphan[0]), 64'd1);
    chk("t6_rsp_cnt", 64'(rsp_cnt[31:0]), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
